// File: rtl/nibble_serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_addsub_ctrl
// Description : Nibble-serial adder/subtractor reusing one 4-bit CLA slice.
// Revision    : 1.0 - initial release
// ============================================================================

module nibble_serial_addsub_ctrl_cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum  = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];

endmodule

// ============================================================================
// Module      : nibble_serial_addsub_ctrl
// Description : IDLE/RUN/DONE controller sequencing the slice over NIB nibbles.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_addsub_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_c_out;
  logic             r_overflow;
  logic             r_zero;

  logic             w_accept;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_sum;
  logic             w_cout;

  // The done cycle is spent in IDLE, so acceptance also waits for it to pass.
  assign w_accept = (r_state == S_IDLE) && start && !r_done;

  always_comb begin
    w_a_nib = 4'd0;
    w_b_nib = 4'd0;
    for (int i = 0; i < NIB; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_a_nib = r_a[i*4 +: 4];
        w_b_nib = r_b[i*4 +: 4];
      end
    end
  end

  nibble_serial_addsub_ctrl_cla4 u_cla4 (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_RUN;
      S_RUN:   if (r_cnt == c_cnt_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_c_out    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != S_IDLE);
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= A;
            r_b     <= op_sub ? ~B : B;
            r_carry <= op_sub;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (r_cnt == CNT_W'(i)) r_result[i*4 +: 4] <= w_sum;
          end
          r_carry <= w_cout;
          r_cnt   <= (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
        end
        S_DONE: begin
          r_done     <= 1'b1;
          r_c_out    <= r_carry;
          r_overflow <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                        (r_result[WIDTH-1] != r_a[WIDTH-1]);
          r_zero     <= (r_result == '0);
        end
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign c_out    = r_c_out;
  assign overflow = r_overflow;
  assign zero     = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_addsub_ctrl
// Description : Directed plus randomized self-checking bench with arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_addsub_ctrl;

  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             clr;
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             overflow;
  logic             zero;

  int n_pass  = 0;
  int n_total = 0;

  nibble_serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .op_sub   (op_sub),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic on the operands.
  // Returns {zero, overflow, c_out, result}.
  function automatic logic [WIDTH+2:0] model(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic sub);
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] r;
    logic             co;
    logic             ov;
    if (sub) begin
      s  = {1'b0, a} - {1'b0, b};
      co = (a >= b);
    end else begin
      s  = {1'b0, a} + {1'b0, b};
      co = s[WIDTH];
    end
    r = s[WIDTH-1:0];
    if (sub) ov = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    else     ov = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    return {(r == '0), ov, co, r};
  endfunction

  task automatic check_flags(input logic [WIDTH+2:0] exp);
    check("result",   result,   exp[WIDTH-1:0]);
    check("c_out",    c_out,    exp[WIDTH]);
    check("overflow", overflow, exp[WIDTH+1]);
    check("zero",     zero,     exp[WIDTH+2]);
  endtask

  // Edges after the accepting edge until done is seen (0 = never within budget).
  task automatic wait_done(input int already, output int lat);
    lat = 0;
    for (int c = already + 1; c <= already + 20; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic sub, input bit poke_done);
    logic [WIDTH+2:0] exp;
    int               lat;
    exp = model(a, b, sub);
    @(negedge clk);
    start = 1'b1; A = a; B = b; op_sub = sub;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom; op_sub = 1'($urandom);
    check("busy_run", busy, 1'b1);
    wait_done(0, lat);
    check("latency", lat, NIB + 1);
    check_flags(exp);
    if (poke_done) begin
      start = 1'b1; A = $urandom; B = $urandom;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_single", done, 1'b0);
    check("result_held", result, exp[WIDTH-1:0]);
    @(posedge clk); #1;
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    int lat;
    int n_done;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    clr = 1'b1; start = 1'b0; op_sub = 1'b0; A = '0; B = '0;
    #1;
    check("rst_busy",     busy,     1'b0);
    check("rst_done",     done,     1'b0);
    check("rst_result",   result,   32'h0);
    check("rst_c_out",    c_out,    1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_zero",     zero,     1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;

    run_op(32'h0000000F, 32'h00000001, 1'b0, 1'b1);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    run_op(32'h00000005, 32'h00000007, 1'b1, 1'b0);
    run_op(32'h00000007, 32'h00000005, 1'b1, 1'b1);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    run_op(32'h80000000, 32'h00000001, 1'b1, 1'b0);
    run_op(32'h00000000, 32'h00000000, 1'b1, 1'b0);

    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      rb = (k % 4 == 0) ? ra : 32'($urandom);
      run_op(ra, rb, 1'($urandom), 1'($urandom));
    end

    // A second start during RUN must be dropped entirely.
    @(negedge clk);
    start = 1'b1; A = 32'h1; B = 32'h1; op_sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; A = 32'h10; B = 32'h10;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3, lat);
    check("ign_latency", lat, NIB + 1);
    check("ign_result", result, 32'h2);
    start = 1'b1;
    n_done = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) n_done++;
    end
    check("ign_no_extra_done", n_done, 0);
    check("ign_result_held", result, 32'h2);

    // Asynchronous clear in the middle of RUN.
    @(negedge clk);
    start = 1'b1; A = 32'h12345678; B = 32'h11111111; op_sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 clr = 1'b1;
    #1;
    check("clr_busy",     busy,     1'b0);
    check("clr_done",     done,     1'b0);
    check("clr_result",   result,   32'h0);
    check("clr_c_out",    c_out,    1'b0);
    check("clr_overflow", overflow, 1'b0);
    check("clr_zero",     zero,     1'b1);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("clr_no_done", n_done, 0);
    run_op(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b0);
    run_op(32'h01234567, 32'hDEADBEEF, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nibble_serial_addsub_ctrl.md
NIBBLE_SERIAL_ADDSUB_CTRL -- requirements
Module: nibble_serial_addsub_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; SHALL be a multiple of 4; NIB = WIDTH/4 slice steps.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 clr  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op_sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-006 A  input  WIDTH  operand A; sampled with start.
REQ-007 B  input  WIDTH  operand B; sampled with start.
REQ-008 busy  output  1  high while an operation is in flight (RUN or DONE).
REQ-009 done  output  1  single-cycle completion pulse.
REQ-010 result  output  WIDTH  sum/difference; held until next accepted start or clr.
REQ-011 c_out  output  1  raw carry out of MSB slice (for sub: 1 = no borrow).
REQ-012 overflow  output  1  two's-complement signed overflow.
REQ-013 zero  output  1  high when result == 0, valid with done and held afterwards.

Function
REQ-014 Datapath SHALL be one instance of the team's 4-bit CLA slice, reused once per nibble; no wider adder allowed.
REQ-015 FSM states SHALL be IDLE, RUN, DONE; encoding free.
REQ-016 IDLE, start=1: latch A into a_reg, (op_sub ? ~B : B) into b_reg, op_sub into carry register, nibble counter = 0; next state RUN.
REQ-017 IDLE, start=0: remain IDLE; outputs held.
REQ-018 RUN, each cycle: slice inputs = nibble[cnt] of a_reg/b_reg plus carry register; slice sum written into result nibble[cnt]; slice carry out written into carry register; cnt += 1.
REQ-019 RUN SHALL last exactly NIB cycles; on cnt == NIB-1 next state DONE, cnt wraps to 0.
REQ-020 DONE: done = 1 for exactly one cycle; c_out = carry register; overflow = (a_reg[MSB] == b_reg[MSB]) & (result[MSB] != a_reg[MSB]); next state IDLE.
REQ-021 Latency: start accepted at edge T -> done high during the cycle following edge T+NIB+1; result/c_out/overflow/zero valid in that cycle and stable until next accepted start.
REQ-022 start while busy (RUN or DONE) SHALL be ignored with no side effect; no queuing.
REQ-023 A, B, op_sub changes after acceptance SHALL NOT affect the in-flight operation.
REQ-024 Back-to-back: start asserted in the cycle done is high is ignored; earliest accepted start is the following IDLE cycle.
REQ-025 Partial result nibbles MAY be visible in result during RUN; consumers SHALL qualify with done.
REQ-026 busy SHALL be a registered function of state (glitch-free).

Reset
REQ-027 clr=1 SHALL immediately force IDLE, cnt=0, carry=0, a_reg=b_reg=0, result=0, c_out=0, overflow=0, busy=0, done=0, zero=1, independent of clk.
REQ-028 clr mid-operation SHALL abort it; no done pulse for the aborted operation.
REQ-029 First start SHALL be accepted on the first rising edge with clr low.

Verification
REQ-030 A=0x0000000F, B=0x00000001, op_sub=0, start at edge T -> done during cycle after edge T+9, result=0x00000010, c_out=0, overflow=0, zero=0.
REQ-031 A=0x7FFFFFFF, B=0x00000001, add -> result=0x80000000, overflow=1, c_out=0.
REQ-032 A=0x00000005, B=0x00000007, sub -> result=0xFFFFFFFE, c_out=0, overflow=0; A=7, B=5, sub -> result=0x00000002, c_out=1.
REQ-033 A=0xFFFFFFFF, B=0x00000001, add -> result=0x00000000, c_out=1, zero=1, overflow=0; A=0x80000000, B=1, sub -> result=0x7FFFFFFF, overflow=1.
REQ-034 start with A=1,B=1, then start with A=0x10,B=0x10 pulsed at RUN cycle 3 -> ignored; single done, result=0x00000002; start in done cycle also ignored.
REQ-035 clr asserted asynchronously at RUN cycle 4 -> all outputs reset per REQ-027 before next edge; no done; a new start after clr deasserts completes normally with full NIB-cycle latency.
